piso_serializer: RTL and testbench

- Upstream feeder for the 4-bit serial-in/parallel-out shift register.
- Accepts parallel words over a valid/ready handshake and shifts them out one bit per clock, MSB first, on `sout`.
- `sout` drives the SIPO `d` input. A SIPO on the same clock therefore holds the original word on `q` after WIDTH shifts.
- Provides framing strobes (`sout_valid`, `last_bit`, `word_done`) so downstream logic can sample the SIPO at the right edge.

---
 rtl/piso_serializer.sv | 148 ++++++++++++++
 tb/tb_piso_serializer.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/piso_serializer.sv
`default_nettype none
// ============================================================================
// Module      : piso_serializer
// Description : Parallel-in / serial-out feeder for a downstream SIPO shift
//               register. Takes WIDTH-bit words over a valid/ready handshake
//               and shifts them out MSB first, one bit per clock, with
//               framing strobes so the receiver knows when its SIPO holds a
//               complete word. An optional fixed idle gap (GAP cycles) can be
//               inserted after every word.
//
// Ports       : clk         rising-edge clock
//               reset       asynchronous, active-high reset
//               din         parallel word to serialize (WIDTH bits)
//               din_valid   din holds a word to transfer
//               din_ready   block can accept din this cycle
//               sout        serial data, MSB first (drives SIPO d)
//               sout_valid  sout carries a data bit this cycle
//               last_bit    sout carries the LSB of the word
//               word_done   one-cycle pulse in the cycle after the LSB
//
// Revision    : 1.0 - initial release
// ============================================================================
module piso_serializer #(
    parameter int WIDTH = 4,
    parameter int GAP   = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             last_bit,
    output logic             word_done
);

    localparam int c_CNT_W = $clog2(WIDTH);
    // A gap counter of GAP <= 1 only ever holds 0; keep it one bit wide.
    localparam int c_GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

    localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(WIDTH - 1);
    localparam logic [c_GAP_W-1:0] c_GAP_LOAD = (GAP > 0) ? c_GAP_W'(GAP - 1) : '0;
    localparam logic               c_GAPLESS  = (GAP == 0);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_SHIFT = 2'd1;
    localparam logic [1:0] c_GAPW  = 2'd2;

    logic [1:0]         state_q,     state_d;
    logic [WIDTH-1:0]   shreg_q,     shreg_d;
    logic [c_CNT_W-1:0] bitcnt_q,    bitcnt_d;
    logic [c_GAP_W-1:0] gapcnt_q,    gapcnt_d;
    logic               word_done_q, word_done_d;

    logic w_shifting;
    logic w_last;

    assign w_shifting = (state_q == c_SHIFT);
    assign w_last     = w_shifting && (bitcnt_q == '0);

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        bitcnt_d    = bitcnt_q;
        gapcnt_d    = gapcnt_q;
        word_done_d = 1'b0;

        case (state_q)
            c_IDLE: begin
                if (din_valid) begin
                    shreg_d  = din;
                    bitcnt_d = c_CNT_LOAD;
                    state_d  = c_SHIFT;
                end
            end

            c_SHIFT: begin
                shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
                if (bitcnt_q == '0) begin
                    word_done_d = 1'b1;
                    if (c_GAPLESS) begin
                        // Back-to-back: the next word replaces the one just
                        // retired without an intervening idle cycle.
                        if (din_valid) begin
                            shreg_d  = din;
                            bitcnt_d = c_CNT_LOAD;
                        end else begin
                            state_d = c_IDLE;
                        end
                    end else begin
                        gapcnt_d = c_GAP_LOAD;
                        state_d  = c_GAPW;
                    end
                end else begin
                    bitcnt_d = bitcnt_q - c_CNT_W'(1);
                end
            end

            c_GAPW: begin
                if (gapcnt_q == '0) begin
                    state_d = c_IDLE;
                end else begin
                    gapcnt_d = gapcnt_q - c_GAP_W'(1);
                end
            end

            default: begin
                state_d = c_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= c_IDLE;
            shreg_q     <= '0;
            bitcnt_q    <= '0;
            gapcnt_q    <= '0;
            word_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            bitcnt_q    <= bitcnt_d;
            gapcnt_q    <= gapcnt_d;
            word_done_q <= word_done_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    // Ready is masked by reset because the cleared state is IDLE, which would
    // otherwise advertise readiness while the block is still held in reset.
    assign din_ready  = !reset && ((state_q == c_IDLE) || (c_GAPLESS && w_last));
    assign sout       = w_shifting ? shreg_q[WIDTH-1] : 1'b0;
    assign sout_valid = w_shifting;
    assign last_bit   = w_last;
    assign word_done  = word_done_q;

endmodule
`default_nettype wire

// File: tb/tb_piso_serializer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_piso_serializer
// Description : Self-checking bench for piso_serializer. Three instances
//               (W4/G0, W4/G2, W8/G0) share clock and reset; one is observed
//               at a time. A cycle-indexed model predicts every output from
//               the accept edge of the word in flight; a bench-side SIPO
//               captures sout so completed words can be compared.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_piso_serializer;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   sel   = 0;

    logic [7:0] din_m   = 8'h00;
    logic       valid_m = 1'b0;

    always #5 clk = ~clk;

    // ---------------------------------------------------------------- DUTs
    logic a_ready, a_sout, a_sv, a_last, a_done;
    logic b_ready, b_sout, b_sv, b_last, b_done;
    logic c_ready, c_sout, c_sv, c_last, c_done;
    logic [3:0] a_din, b_din;
    logic [7:0] c_din;
    logic       a_valid, b_valid, c_valid;

    assign a_din   = din_m[3:0];
    assign b_din   = din_m[3:0];
    assign c_din   = din_m;
    assign a_valid = valid_m && (sel == 0);
    assign b_valid = valid_m && (sel == 1);
    assign c_valid = valid_m && (sel == 2);

    piso_serializer #(.WIDTH(4), .GAP(0)) u_a (
        .clk(clk), .reset(reset), .din(a_din), .din_valid(a_valid),
        .din_ready(a_ready), .sout(a_sout), .sout_valid(a_sv),
        .last_bit(a_last), .word_done(a_done));

    piso_serializer #(.WIDTH(4), .GAP(2)) u_b (
        .clk(clk), .reset(reset), .din(b_din), .din_valid(b_valid),
        .din_ready(b_ready), .sout(b_sout), .sout_valid(b_sv),
        .last_bit(b_last), .word_done(b_done));

    piso_serializer #(.WIDTH(8), .GAP(0)) u_c (
        .clk(clk), .reset(reset), .din(c_din), .din_valid(c_valid),
        .din_ready(c_ready), .sout(c_sout), .sout_valid(c_sv),
        .last_bit(c_last), .word_done(c_done));

    logic obs_ready, obs_sout, obs_sv, obs_last, obs_done;
    assign obs_ready = (sel == 0) ? a_ready : (sel == 1) ? b_ready : c_ready;
    assign obs_sout  = (sel == 0) ? a_sout  : (sel == 1) ? b_sout  : c_sout;
    assign obs_sv    = (sel == 0) ? a_sv    : (sel == 1) ? b_sv    : c_sv;
    assign obs_last  = (sel == 0) ? a_last  : (sel == 1) ? b_last  : c_last;
    assign obs_done  = (sel == 0) ? a_done  : (sel == 1) ? b_done  : c_done;

    // Receiver-side SIPO fed by the observed serial output.
    logic [7:0] sipo = 8'h00;
    always @(posedge clk) sipo <= {sipo[6:0], obs_sout};

    // ---------------------------------------------------------------- checks
    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    function automatic int cfg_w();
        return (sel == 2) ? 8 : 4;
    endfunction

    function automatic int cfg_g();
        return (sel == 1) ? 2 : 0;
    endfunction

    function automatic logic [7:0] wmask(input logic [7:0] v);
        return (cfg_w() == 8) ? v : {4'h0, v[3:0]};
    endfunction

    // ---------------------------------------------------------------- model
    // A word accepted at edge k owns cycles k..k+W-1 (cycle t = interval
    // after edge t), word_done falls in cycle k+W, and the block is free
    // again from cycle k+W+GAP (gapless mode also re-accepts in k+W-1).
    int         k_cur, cur_done, prev_done;
    logic [7:0] cur_word, prev_word;

    function automatic logic exp_ready(input int t);
        int w, g;
        w = cfg_w();
        g = cfg_g();
        return !reset && ((t >= k_cur + w + g) || (g == 0 && t == k_cur + w - 1));
    endfunction

    task automatic clear_model();
        k_cur     = -1000;
        cur_done  = -1000;
        prev_done = -1000;
        cur_word  = 8'h00;
        prev_word = 8'h00;
    endtask

    task automatic compare_cycle();
        int t, w, idx;
        logic in_w, e_s, e_d;
        logic [7:0] ew;
        t    = cyc;
        w    = cfg_w();
        in_w = (t >= k_cur) && (t < k_cur + w);
        e_s  = 1'b0;
        if (in_w) begin
            idx = w - 1 - (t - k_cur);
            e_s = cur_word[idx];
        end
        e_d = (t == cur_done) || (t == prev_done);
        chk("sout",       obs_sout,  e_s);
        chk("sout_valid", obs_sv,    in_w);
        chk("last_bit",   obs_last,  in_w && (t == k_cur + w - 1));
        chk("word_done",  obs_done,  e_d);
        chk("din_ready",  obs_ready, exp_ready(t));
        if (e_d) begin
            ew = (t == cur_done) ? cur_word : prev_word;
            chk("sipo_word", wmask(sipo), ew);
        end
    endtask

    initial begin : model_and_compare
        logic last_clk;
        last_clk = 1'b0;
        clear_model();
        forever begin
            @(clk or reset);
            if (reset) clear_model();
            if (clk && !last_clk) begin
                if (!reset && valid_m && exp_ready(cyc)) begin
                    prev_done = cur_done;
                    prev_word = cur_word;
                    k_cur     = cyc + 1;
                    cur_word  = wmask(din_m);
                    cur_done  = k_cur + cfg_w();
                end
                cyc++;
            end else if (!clk && last_clk) begin
                compare_cycle();
            end
            last_clk = clk;
        end
    end

    // ---------------------------------------------------------------- stimulus
    // All tasks start and end just after a falling edge.
    task automatic send(input logic [7:0] w, output int dly);
        int n;
        n       = 0;
        din_m   = w;
        valid_m = 1'b1;
        while (!obs_ready && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (n >= 64) begin
            total++;
            bad++;
            $display("FAIL send_timeout cycle=%0d got=not_ready expected=ready", cyc);
        end
        @(negedge clk);
        valid_m = 1'b0;
        din_m   = 8'h00;
        dly     = n + 1;
    endtask

    task automatic capture(input int w, output logic [7:0] bits, output int nvalid, output int nlast);
        bits   = 8'h00;
        nvalid = 0;
        nlast  = 0;
        for (int i = 0; i < w; i++) begin
            bits   = {bits[6:0], obs_sout};
            nvalid = nvalid + int'(obs_sv);
            nlast  = nlast + int'(obs_last);
            @(negedge clk);
        end
    endtask

    task automatic switch_cfg(input int new_sel);
        #1 reset = 1'b1;
        sel = new_sel;
        repeat (2) @(negedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic random_phase(input int ncyc);
        for (int i = 0; i < ncyc; i++) begin
            valid_m = ($urandom_range(0, 3) != 0);
            din_m   = 8'($urandom);
            if ($urandom_range(0, 99) == 0) begin
                #2 reset = 1'b1;
                @(negedge clk);
                #1 reset = 1'b0;
            end
            @(negedge clk);
        end
        valid_m = 1'b0;
        repeat (16) @(negedge clk);
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog cycle=%0d got=timeout expected=finish", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [7:0] bits;
        int nv, nl, d1, d2;

        // Reset state.
        @(negedge clk);
        chk("rst_ready", obs_ready, 0);
        chk("rst_sout_valid", obs_sv, 0);
        chk("rst_word_done", obs_done, 0);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("release_ready", obs_ready, 1);

        // Single word 1011.
        send(8'h0B, d1);
        capture(4, bits, nv, nl);
        chk("t1_bits", bits, 8'h0B);
        chk("t1_nvalid", nv, 4);
        chk("t1_nlast", nl, 1);
        chk("t1_done", obs_done, 1);
        chk("t1_sipo", {4'h0, sipo[3:0]}, 4'hB);
        chk("t1_idle_after", obs_sv, 0);

        // Gapless pair 1011 then 0110.
        send(8'h0B, d1);
        send(8'h06, d2);
        chk("t2_accept_spacing", d2, 4);
        capture(4, bits, nv, nl);
        chk("t2_bits2", bits, 8'h06);
        chk("t2_done2", obs_done, 1);
        chk("t2_sipo2", {4'h0, sipo[3:0]}, 4'h6);

        // Reset during the second bit of 1111.
        send(8'h0F, d1);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("t4_sout_drop", obs_sout, 0);
        chk("t4_valid_drop", obs_sv, 0);
        chk("t4_ready_drop", obs_ready, 0);
        @(negedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("t4_ready_release", obs_ready, 1);
        send(8'h05, d1);
        capture(4, bits, nv, nl);
        chk("t4_bits", bits, 8'h05);
        chk("t4_done", obs_done, 1);

        // Input changes after accept are ignored.
        send(8'h09, d1);
        capture(4, bits, nv, nl);
        chk("t5_bits", bits, 8'h09);

        random_phase(400);

        // GAP=2 instance.
        switch_cfg(1);
        send(8'h0B, d1);
        send(8'h06, d2);
        chk("t3_accept_spacing", d2, 7);
        capture(4, bits, nv, nl);
        chk("t3_bits2", bits, 8'h06);
        chk("t3_done2", obs_done, 1);
        chk("t3_gap_ready", obs_ready, 0);
        random_phase(400);

        // WIDTH=8 instance.
        switch_cfg(2);
        send(8'hA5, d1);
        capture(8, bits, nv, nl);
        chk("t6_bits", bits, 8'hA5);
        chk("t6_nvalid", nv, 8);
        chk("t6_done", obs_done, 1);
        chk("t6_sipo", sipo, 8'hA5);
        random_phase(400);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
